// File: rtl/led_matrix_pkg.sv
// Shared types and default constants for the row-multiplexed LED matrix scanner.
package led_matrix_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam int DEF_N       = 8;
    localparam int DEF_DIVIDER = 4;
    localparam int DEF_BLANK   = 1;

    // Counter width for a modulo-count counter; never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/row_scan_counter.sv
// Slot timer and row index for the scanner: BLANK phase, DRIVE phase, next row.
import led_matrix_pkg::*;

module row_scan_counter #(
    parameter int N       = DEF_N,
    parameter int DIVIDER = DEF_DIVIDER,
    parameter int BLANK   = DEF_BLANK
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    output scan_state_t                                state,
    output logic [$clog2(N)-1:0]                       row,
    output logic [cnt_width(BLANK + 2**DIVIDER)-1:0]   slot_cnt,
    output logic                                       frame_wrap
);

    localparam int CW        = cnt_width(BLANK + 2**DIVIDER);
    localparam int RW        = $clog2(N);
    localparam int DRIVE_LEN = 2**DIVIDER;

    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_LEN - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    // With blanking disabled every slot begins directly in DRIVE.
    localparam scan_state_t   FIRST_STATE = (BLANK > 0) ? S_BLANK : S_DRIVE;

    scan_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [RW-1:0] row_reg, row_next;
    logic          wrap_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FIRST_STATE;
            cnt_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            row_reg   <= row_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        row_next   = row_reg;
        wrap_next  = 1'b0;
        case (state_reg)
            S_BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = S_DRIVE;
                    cnt_next   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_reg == DRIVE_LAST) begin
                    state_next = FIRST_STATE;
                    cnt_next   = '0;
                    if (row_reg == ROW_LAST) begin
                        row_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = FIRST_STATE;
                cnt_next   = '0;
            end
        endcase
    end

    assign state      = state_reg;
    assign row        = row_reg;
    assign slot_cnt   = cnt_reg;
    assign frame_wrap = wrap_next;

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered N x N LED matrix row scanner with valid/ready frame intake.
import led_matrix_pkg::*;

module led_matrix_scanner #(
    parameter int N       = DEF_N,
    parameter int DIVIDER = DEF_DIVIDER,
    parameter int BLANK   = DEF_BLANK
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*N-1:0] cells_i,
    input  logic           frame_valid_i,
    output logic           frame_ready_o,
    output logic [N-1:0]   rows,
    output logic [N-1:0]   cols,
    output logic           frame_start_o
);

    localparam int CW = cnt_width(BLANK + 2**DIVIDER);
    localparam int RW = $clog2(N);
    localparam scan_state_t FIRST_STATE = (BLANK > 0) ? S_BLANK : S_DRIVE;

    scan_state_t   scan_state;
    logic [RW-1:0] scan_row;
    logic [CW-1:0] slot_cnt;
    logic          frame_wrap;

    row_scan_counter #(
        .N       (N),
        .DIVIDER (DIVIDER),
        .BLANK   (BLANK)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (scan_state),
        .row        (scan_row),
        .slot_cnt   (slot_cnt),
        .frame_wrap (frame_wrap)
    );

    logic [N*N-1:0] pending_reg, display_reg;
    logic           pending_full_reg, pending_full_next;
    logic           ready_reg;
    logic           accept;
    logic [N-1:0]   rows_reg, rows_next;
    logic [N-1:0]   cols_reg, cols_next;
    logic           frame_start_reg, frame_start_next;

    // ready mirrors !pending_full, so an accept and a swap never coincide.
    assign accept = frame_valid_i && ready_reg;

    always_comb begin
        pending_full_next = pending_full_reg;
        if (accept)
            pending_full_next = 1'b1;
        else if (frame_wrap)
            pending_full_next = 1'b0;
    end

    // Output registers decode the counter one cycle behind, so the wrap edge
    // still shows the old frame's last row and row 0 sees the swapped buffer.
    always_comb begin
        rows_next        = '0;
        cols_next        = '1;
        frame_start_next = (scan_row == '0) && (slot_cnt == '0) && (scan_state == FIRST_STATE);
        if (scan_state == S_DRIVE) begin
            rows_next[scan_row] = 1'b1;
            cols_next           = ~display_reg[scan_row*N +: N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg      <= '0;
            display_reg      <= '0;
            pending_full_reg <= 1'b0;
            ready_reg        <= 1'b1;
            rows_reg         <= '0;
            cols_reg         <= '1;
            frame_start_reg  <= 1'b0;
        end else begin
            if (accept)
                pending_reg <= cells_i;
            if (frame_wrap && pending_full_reg)
                display_reg <= pending_reg;
            pending_full_reg <= pending_full_next;
            ready_reg        <= !pending_full_next;
            rows_reg         <= rows_next;
            cols_reg         <= cols_next;
            frame_start_reg  <= frame_start_next;
        end
    end

    assign frame_ready_o = ready_reg;
    assign rows          = rows_reg;
    assign cols          = cols_reg;
    assign frame_start_o = frame_start_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench: two scanner instances (N=8/DIV=1/BLANK=1 and N=8/DIV=0/BLANK=0) against a frame-position model.
module tb_led_matrix_scanner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [2];
    logic        valid   [2];
    logic [63:0] cells   [2];
    logic        ready_w [2];
    logic [7:0]  rows_w  [2];
    logic [7:0]  cols_w  [2];
    logic        fs_w    [2];

    led_matrix_scanner #(.N(8), .DIVIDER(1), .BLANK(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cells_i(cells[0]), .frame_valid_i(valid[0]),
        .frame_ready_o(ready_w[0]), .rows(rows_w[0]), .cols(cols_w[0]), .frame_start_o(fs_w[0])
    );

    led_matrix_scanner #(.N(8), .DIVIDER(0), .BLANK(0)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cells_i(cells[1]), .frame_valid_i(valid[1]),
        .frame_ready_o(ready_w[1]), .rows(rows_w[1]), .cols(cols_w[1]), .frame_start_o(fs_w[1])
    );

    // Reference model: slot length and blank cycles per instance.
    int          slot_m [2] = '{3, 1};
    int          blank_m[2] = '{1, 0};
    int          k_m    [2];
    logic [63:0] disp_m [2];
    logic [63:0] pend_m [2];
    bit          pf_m   [2];
    bit          acc_m  [2];
    logic [7:0]  er     [2];
    logic [7:0]  ec     [2];
    bit          efs    [2];
    bit          erdy   [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        k_m[i] = 0; disp_m[i] = '0; pend_m[i] = '0; pf_m[i] = 0; acc_m[i] = 0;
        er[i] = 8'h00; ec[i] = 8'hFF; efs[i] = 0; erdy[i] = 1;
    endtask

    // One clock edge: outputs show scan position k using the display held before the edge.
    task automatic model_edge(input int i);
        int ns, p, r, off;
        if (!rst_n[i]) begin
            model_reset(i);
            return;
        end
        ns  = 8 * slot_m[i];
        p   = k_m[i] % ns;
        r   = p / slot_m[i];
        off = p % slot_m[i];
        efs[i] = (p == 0);
        if (off < blank_m[i]) begin
            er[i] = 8'h00;
            ec[i] = 8'hFF;
        end else begin
            er[i] = 8'(1 << r);
            ec[i] = ~disp_m[i][r*8 +: 8];
        end
        acc_m[i] = valid[i] && !pf_m[i];
        if (p == ns - 1 && pf_m[i]) begin
            disp_m[i] = pend_m[i];
            pf_m[i]   = 0;
        end
        if (acc_m[i]) begin
            pend_m[i] = cells[i];
            pf_m[i]   = 1;
        end
        erdy[i] = !pf_m[i];
        k_m[i]++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rows%0d", i), 64'(rows_w[i]), 64'(er[i]));
            chk($sformatf("cols%0d", i), 64'(cols_w[i]), 64'(ec[i]));
            chk($sformatf("frame_start%0d", i), 64'(fs_w[i]), 64'(efs[i]));
            chk($sformatf("ready%0d", i), 64'(ready_w[i]), 64'(erdy[i]));
        end
        if (rst_n[1] && k_m[1] > 0)
            chk("onehot1", 64'($countones(rows_w[1])), 64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
        valid[1] = ($urandom_range(0, 3) == 0);
        cells[1] = {$urandom, $urandom};
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic wait_pos(input int i, input int pos, input int budget);
        int n = 0;
        while ((k_m[i] % (8 * slot_m[i])) != pos && n < budget) begin
            step();
            n++;
        end
        chk("wait_pos", 64'((k_m[i] % (8 * slot_m[i])) == pos), 64'd1);
    endtask

    task automatic load0(input logic [63:0] f);
        valid[0] = 1'b1;
        cells[0] = f;
        step();
        valid[0] = 1'b0;
        chk("ready_drop", 64'(ready_w[0]), 64'd0);
    endtask

    logic [63:0] cb;
    int          n_wait;

    initial begin
        rst_n[0] = 0; rst_n[1] = 0;
        valid[0] = 0; valid[1] = 0;
        cells[0] = '0; cells[1] = '0;
        model_reset(0); model_reset(1);
        #12;
        check_all();

        @(posedge clk); #1;
        rst_n[0] = 1; rst_n[1] = 1;

        // Idle scan with an all-zero display.
        run(30);

        // Checkerboard loaded mid-frame.
        for (int r = 0; r < 8; r++) cb[r*8 +: 8] = (r % 2 == 0) ? 8'h55 : 8'hAA;
        wait_pos(0, 10, 50);
        load0(cb);
        run(60);

        // Second frame held valid while pending is full.
        load0({$urandom, $urandom});
        valid[0] = 1'b1;
        cells[0] = {$urandom, $urandom};
        n_wait = 0;
        while (n_wait < 100) begin
            step();
            n_wait++;
            if (acc_m[0]) break;
        end
        valid[0] = 1'b0;
        chk("held_accept", 64'(ready_w[0]), 64'd0);
        run(60);

        // Handshake on the exact boundary cycle with pending empty.
        wait_pos(0, 23, 50);
        load0({$urandom, $urandom});
        run(50);

        // Asynchronous reset in row 5 DRIVE with a pending frame.
        wait_pos(0, 1, 50);
        load0({$urandom, $urandom});
        wait_pos(0, 16, 50);
        step();
        chk("row5_drive", 64'(rows_w[0]), 64'h20);
        #2;
        rst_n[0] = 0;
        #1;
        model_reset(0);
        check_all();
        run(3);
        rst_n[0] = 1;
        run(30);

        // Randomised traffic on both instances.
        for (int j = 0; j < 400; j++) begin
            valid[0] = ($urandom_range(0, 3) == 0);
            cells[0] = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
